// File: rtl/secure_lock_pkg.sv
// Shared types and default constants for the secure lock controller.
package secure_lock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_fsm_e;

  localparam logic [31:0] DEF_UNLOCK_KEY     = 32'hA5C3_0F96;
  localparam int          DEF_MAX_ATTEMPTS   = 3;
  localparam int          DEF_LOCKOUT_CYCLES = 1024;

endpackage

// File: rtl/secure_lock_ctrl_if.sv
// Debug-unlock request/response handshake between a debug agent and secure_lock_ctrl.
interface secure_lock_ctrl_if #(
  parameter int KEY_W = 32
) ();

  logic             unlock_valid;
  logic [KEY_W-1:0] unlock_key;
  logic             unlock_ready;
  logic             resp_valid;
  logic             resp_ok;

  modport master (
    output unlock_valid, unlock_key,
    input  unlock_ready, resp_valid, resp_ok
  );

  modport slave (
    input  unlock_valid, unlock_key,
    output unlock_ready, resp_valid, resp_ok
  );

endinterface

// File: rtl/secure_lock_ctrl_lock_bank.sv
// Sticky per-register lock flags; once set only reset clears them.
module lock_bank #(
  parameter int NUM_REGS = 3
) (
  input  logic                Clk,
  input  logic                resetn,
  input  logic [NUM_REGS-1:0] lock_req,
  output logic [NUM_REGS-1:0] lock_status
);

  logic [NUM_REGS-1:0] lock_status_r;

  // Accumulate lock requests; there is deliberately no clear path besides reset.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      lock_status_r <= {NUM_REGS{1'b0}};
    end else begin
      lock_status_r <= lock_status_r | lock_req;
    end
  end

  assign lock_status = lock_status_r;

endmodule

// File: rtl/secure_lock_ctrl.sv
// Register lock bank plus debug-unlock FSM with attempt limiting and timed lockout.
// Optional scan guard: define SECURE_LOCK_SCAN_GUARD_EN.
module secure_lock_ctrl
  import secure_lock_pkg::*;
#(
  parameter int               NUM_REGS       = 3,
  parameter int               KEY_W          = 32,
  parameter logic [KEY_W-1:0] UNLOCK_KEY     = KEY_W'(DEF_UNLOCK_KEY),
  parameter int               MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int               LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                Clk,
  input  logic                resetn,
  input  logic [NUM_REGS-1:0] lock_req,
  input  logic                relock,
  input  logic                scan_mode,
  secure_lock_ctrl_if.slave   ul,
  output logic [NUM_REGS-1:0] lock_status,
  output logic                debug_unlocked,
  output logic                lockout
);

  localparam int FAIL_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_ATTEMPTS);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  lock_fsm_e         state_r, state_s;
  logic [FAIL_W-1:0] fail_cnt_r, fail_cnt_s;
  logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_s;
  logic [KEY_W-1:0]  key_r;
  logic              resp_valid_r, resp_ok_r, debug_unlocked_r, lockout_r, unlock_ready_r;
  logic              force_idle_s, scan_ok_s, ready_s, accept_s, key_match_s;

`ifdef SECURE_LOCK_SCAN_GUARD_EN
  // Scan entry with locked registers must never leave the debug bypass open.
  assign force_idle_s = scan_mode & (|lock_status);
  assign scan_ok_s    = ~scan_mode;
`else
  logic unused_scan_s;
  assign unused_scan_s = scan_mode;
  assign force_idle_s  = 1'b0;
  assign scan_ok_s     = 1'b1;
`endif

  assign ready_s     = unlock_ready_r & scan_ok_s;
  assign accept_s    = ul.unlock_valid & ready_s;
  assign key_match_s = (key_r == UNLOCK_KEY);

  lock_bank #(.NUM_REGS(NUM_REGS)) u_lock_bank (
    .Clk         (Clk),
    .resetn      (resetn),
    .lock_req    (lock_req),
    .lock_status (lock_status)
  );

  // Next-state and counter updates for the unlock FSM.
  always_comb begin
    state_s    = state_r;
    fail_cnt_s = fail_cnt_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CHECK;
        else          state_s = IDLE;
      end
      CHECK: begin
        if (key_match_s) begin
          fail_cnt_s = {FAIL_W{1'b0}};
          state_s    = UNLOCKED;
        end else begin
          fail_cnt_s = (fail_cnt_r == FAIL_MAX) ? FAIL_MAX : fail_cnt_r + FAIL_W'(1);
          if (fail_cnt_s == FAIL_MAX) begin
            state_s    = LOCKOUT;
            lock_cnt_s = LOCK_LOAD;
          end else begin
            state_s = IDLE;
          end
        end
      end
      UNLOCKED: begin
        if (relock || force_idle_s) state_s = IDLE;
        else                        state_s = UNLOCKED;
      end
      LOCKOUT: begin
        if (lock_cnt_r == {LOCK_W{1'b0}}) begin
          state_s    = IDLE;
          fail_cnt_s = {FAIL_W{1'b0}};
        end else begin
          lock_cnt_s = lock_cnt_r - LOCK_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, captured key and registered outputs.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_r          <= IDLE;
      fail_cnt_r       <= {FAIL_W{1'b0}};
      lock_cnt_r       <= {LOCK_W{1'b0}};
      key_r            <= {KEY_W{1'b0}};
      resp_valid_r     <= 1'b0;
      resp_ok_r        <= 1'b0;
      debug_unlocked_r <= 1'b0;
      lockout_r        <= 1'b0;
      unlock_ready_r   <= 1'b0;
    end else begin
      state_r          <= state_s;
      fail_cnt_r       <= fail_cnt_s;
      lock_cnt_r       <= lock_cnt_s;
      if (accept_s) begin
        key_r <= ul.unlock_key;
      end else begin
        key_r <= key_r;
      end
      resp_valid_r     <= (state_r == CHECK);
      resp_ok_r        <= (state_r == CHECK) & key_match_s;
      debug_unlocked_r <= (state_s == UNLOCKED);
      lockout_r        <= (state_s == LOCKOUT);
      unlock_ready_r   <= (state_s == IDLE);
    end
  end

  assign ul.unlock_ready = ready_s;
  assign ul.resp_valid   = resp_valid_r;
  assign ul.resp_ok      = resp_ok_r;
  assign debug_unlocked  = debug_unlocked_r & scan_ok_s;
  assign lockout         = lockout_r;

endmodule
